alu_ctrl_md: RTL and testbench

Next-generation ALU control for the EX stage. It performs the existing RV32I decode of `alu_op`/`funct3`/`funct7` into a 5-bit ALU control code, adds RV32M decode, and owns an iterative multiply/divide sequencer with a pipeline stall handshake. Sits between ID/EX pipeline register and ALU; `md_busy_o` feeds the hazard unit.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_ctrl_md_md_iter.sv | 81 ++++++++
 rtl/alu_ctrl_md.sv | 116 +++++++++++
 tb/tb_alu_ctrl_md.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, alu_op classes, RV32M funct3 values and sequencer states
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SLT,
        ALU_SLTU, ALU_SRL, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_JALR, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
        ALU_DIVU, ALU_REM, ALU_REMU
    } alu_code_e;

    localparam logic [2:0] OP_R  = 3'b000;
    localparam logic [2:0] OP_I  = 3'b001;
    localparam logic [2:0] OP_SL = 3'b010;
    localparam logic [2:0] OP_B  = 3'b011;
    localparam logic [2:0] OP_U  = 3'b100;
    localparam logic [2:0] OP_J  = 3'b101;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

endpackage

// File: rtl/alu_ctrl_md_md_iter.sv
// md_iter: radix-2 multiply/divide datapath on operand magnitudes with final sign fix
module md_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0]   hi, lo, m, mag_a, mag_b, nhi, nlo, qr, fin, spec_val;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              neg, sa, sb, div_zero, ovf;

    // operand magnitudes and divides that finish without iterating
    always_comb begin
        sa       = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU}) && a[XLEN-1];
        sb       = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU, F3_MULHSU}) && b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        div_zero = funct3[2] && b == '0;
        ovf      = funct3 inside {F3_DIV, F3_REM} && a == MIN && b == '1;
        special  = div_zero || ovf;
        spec_val = ovf ? (funct3[1] ? '0 : MIN) : (funct3[1] ? a : '1);
    end

    // one shift-add or restoring-divide step, plus the sign-fixed final value
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        trial = {hi, lo[XLEN-1]} - {1'b0, m};
        nhi   = f3[2] ? (trial[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1]} : trial[XLEN-1:0]) : sum[XLEN:1];
        nlo   = f3[2] ? {lo[XLEN-2:0], !trial[XLEN]} : {sum[0], lo[XLEN-1:1]};
        prod  = neg ? -{nhi, nlo} : {nhi, nlo};
        qr    = f3[1] ? nhi : nlo;
        fin   = f3[2] ? (neg ? -qr : qr) : (f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        last  = cnt == '0;
    end

    // operand capture on accept, iteration while stepping, result on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            cnt    <= '0;
            f3     <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= mag_a;
            m   <= mag_b;
            cnt <= CW'(XLEN - 1);
            f3  <= funct3;
            neg <= funct3 inside {F3_REM, F3_REMU} ? sa : sa ^ sb;
            if (special)
                result <= spec_val;
        end else if (step) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= last ? cnt : cnt - 1'b1;
            if (last)
                result <= fin;
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: EX-stage ALU control decode with optional RV32M sequencer (enabled by ALU_MEXT_EN)
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic            mem_r,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [4:0]      ALUCtrl,
    output logic            md_busy_o,
    output logic            md_done_o,
    output logic [XLEN-1:0] md_result_o
);

    alu_code_e code;

`ifdef ALU_MEXT_EN
    logic m_op;
    assign m_op = alu_op == OP_R && funct7 == F7_MEXT;
`endif

    // base RV32I decode, with M-ops overriding the R class when enabled
    always_comb begin
        code = ALU_NOP;
        case (alu_op)
            OP_R, OP_I:
                case (funct3)
                    3'b000:  code = (alu_op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            OP_SL:   code = funct3 inside {3'b011, 3'b110, 3'b111} ? ALU_NOP : ALU_ADD;
            OP_B:
                case (funct3)
                    3'b000:  code = ALU_BEQ;
                    3'b001:  code = ALU_BNE;
                    3'b100:  code = ALU_BLT;
                    3'b101:  code = ALU_BGE;
                    3'b110:  code = ALU_BLTU;
                    3'b111:  code = ALU_BGEU;
                    default: code = ALU_NOP;
                endcase
            OP_U:    code = funct3 == 3'b000 ? ALU_JALR : ALU_NOP;
            OP_J:    code = ALU_NOP;
            default: code = ALU_NOP;
        endcase
`ifdef ALU_MEXT_EN
        if (m_op)
            code = alu_code_e'(5'(ALU_MUL) + {2'b00, funct3});
`endif
        ALUCtrl = code;
    end

`ifdef ALU_MEXT_EN
    md_state_e state, state_nx;
    logic      accept, special, last;
    logic      unused_ok;

    assign unused_ok = mem_r;

    // sequencer state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next state and stall/done handshake; a flush abandons the op silently
    always_comb begin
        state_nx  = state;
        accept    = state == S_IDLE && valid_i && m_op && !flush_i;
        md_busy_o = accept || state == S_BUSY;
        md_done_o = state == S_DONE && !flush_i;
        case (state)
            S_IDLE:  state_nx = accept ? (special ? S_DONE : S_BUSY) : S_IDLE;
            S_BUSY:  state_nx = flush_i ? S_IDLE : (last ? S_DONE : S_BUSY);
            default: state_nx = S_IDLE;
        endcase
    end

    md_iter #(.XLEN(XLEN)) u_md_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (state == S_BUSY && !flush_i),
        .funct3  (funct3),
        .a       (rs1_i),
        .b       (rs2_i),
        .special (special),
        .last    (last),
        .result  (md_result_o)
    );
`else
    logic unused_ok;

    assign unused_ok   = ^{clk, rst, valid_i, flush_i, mem_r, funct7[6], funct7[4:0], rs1_i, rs2_i};
    assign md_busy_o   = 1'b0;
    assign md_done_o   = 1'b0;
    assign md_result_o = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: directed and scoreboarded checks of decode and the M-op sequencer
module tb_alu_ctrl_md;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mem_r = 1'b0;
    logic [2:0]  alu_op = 3'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [6:0]  funct7 = 7'b0;
    logic [31:0] rs1_i = 32'b0;
    logic [31:0] rs2_i = 32'b0;
    logic [4:0]  ALUCtrl;
    logic        md_busy_o, md_done_o;
    logic [31:0] md_result_o;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'b0;

    alu_ctrl_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .mem_r(mem_r),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .ALUCtrl(ALUCtrl), .md_busy_o(md_busy_o), .md_done_o(md_done_o), .md_result_o(md_result_o)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [2:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic v, input logic [4:0] code);
        alu_op  = op;
        funct3  = f3;
        funct7  = f7;
        valid_i = v;
        #1;
        chk(tag, 32'(ALUCtrl), 32'(code));
        chk({tag, "/busy"}, 32'(md_busy_o), 32'd0);
        valid_i = 1'b0;
    endtask

    function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ubl = longint'({32'b0, b});
        logic [63:0] p;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ubl); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int md_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // issue one M-op, hold a conflicting op on the bus while busy, then score the result
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        sb_t e;
        int  n;
        int  busy_low;
        sb_q.push_back('{tag, exp, lat});
        alu_op  = 3'b000;
        funct7  = 7'b0000001;
        funct3  = f3;
        rs1_i   = a;
        rs2_i   = b;
        valid_i = 1'b1;
        #1;
        chk({tag, "/code"}, 32'(ALUCtrl), 32'(5'd18 + {2'b00, f3}));
        chk({tag, "/busyT"}, 32'(md_busy_o), 32'd1);
        tick;
        funct3   = 3'b101;
        rs2_i    = 32'b0;
        n        = 1;
        busy_low = 0;
        while (!md_done_o && n < 100) begin
            if (!md_busy_o) busy_low++;
            tick;
            n++;
        end
        valid_i = 1'b0;
        e = sb_q.pop_front();
        chk({e.tag, "/latency"}, 32'(n), 32'(e.lat));
        chk({e.tag, "/result"}, md_result_o, e.res);
        chk({e.tag, "/busy_in_done"}, 32'(md_busy_o), 32'd0);
        chk({e.tag, "/busy_gaps"}, 32'(busy_low), 32'd0);
        last_exp = e.res;
        tick;
        chk({e.tag, "/done_one_cycle"}, 32'(md_done_o), 32'd0);
    endtask

    // directed sequence
    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          dones;
        tick;
        tick;
        chk("reset/busy", 32'(md_busy_o), 32'd0);
        chk("reset/done", 32'(md_done_o), 32'd0);
        chk("reset/result", md_result_o, 32'd0);
        rst = 1'b0;
        tick;

        dec("r_add",  3'b000, 3'b000, 7'b0000000, 1'b1, 5'd1);
        dec("r_sub",  3'b000, 3'b000, 7'b0100000, 1'b1, 5'd2);
        dec("r_sra",  3'b000, 3'b101, 7'b0100000, 1'b1, 5'd10);
        dec("r_srl",  3'b000, 3'b101, 7'b0000000, 1'b1, 5'd9);
        dec("i_xori", 3'b001, 3'b100, 7'b0101010, 1'b1, 5'd5);
        dec("i_addi", 3'b001, 3'b000, 7'b0100000, 1'b1, 5'd1);
        dec("i_sltiu",3'b001, 3'b011, 7'b0000000, 1'b1, 5'd8);
        dec("sl_lw",  3'b010, 3'b010, 7'b0000000, 1'b1, 5'd1);
        dec("sl_bad", 3'b010, 3'b011, 7'b0000000, 1'b1, 5'd0);
        dec("b_bgeu", 3'b011, 3'b111, 7'b0000000, 1'b1, 5'd16);
        dec("b_beq",  3'b011, 3'b000, 7'b0000000, 1'b1, 5'd11);
        dec("b_bad",  3'b011, 3'b010, 7'b0000000, 1'b1, 5'd0);
        dec("jalr",   3'b100, 3'b000, 7'b0000000, 1'b1, 5'd17);
        dec("j_cls",  3'b101, 3'b000, 7'b0000000, 1'b1, 5'd0);
        dec("cls110", 3'b110, 3'b000, 7'b0000000, 1'b1, 5'd0);

`ifdef ALU_MEXT_EN
        dec("m_mul_code",  3'b000, 3'b000, 7'b0000001, 1'b0, 5'd18);
        dec("m_remu_code", 3'b000, 3'b111, 7'b0000001, 1'b0, 5'd25);

        run_md("mul_neg",     3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 33);
        run_md("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulh_neg",    3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 33);
        run_md("mulhsu",      3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_md("div_7_m2",    3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_md("rem_7_m2",    3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run_md("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_md("divu_by0",    3'd5, 32'd100,       32'd0,        32'hFFFF_FFFF, 1);
        run_md("remu_by0",    3'd7, 32'd100,       32'd0,        32'd100,       1);
        run_md("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_md("divu_big",    3'd5, 32'hFFFF_FFFF, 32'd3,        32'h5555_5555, 33);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2) == 1 ? 32'($urandom_range(1, 50)) : $urandom);
            run_md("rnd", rf, ra, rb, md_model(rf, ra, rb), md_lat(rf, ra, rb));
        end

        alu_op  = 3'b000;
        funct7  = 7'b0000001;
        funct3  = 3'd5;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        repeat (4) tick;
        chk("flush/busy_T5", 32'(md_busy_o), 32'd1);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("flush/busy_T6", 32'(md_busy_o), 32'd0);
        chk("flush/done_T6", 32'(md_done_o), 32'd0);
        chk("flush/result_held", md_result_o, last_exp);
        dones = 0;
        repeat (40) begin
            tick;
            if (md_done_o) dones++;
        end
        chk("flush/no_done", 32'(dones), 32'd0);
        chk("flush/result_still_held", md_result_o, last_exp);

        rs1_i   = 32'd5;
        rs2_i   = 32'd5;
        funct3  = 3'd0;
        valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        chk("rst_mid/busy", 32'(md_busy_o), 32'd0);
        chk("rst_mid/done", 32'(md_done_o), 32'd0);
        chk("rst_mid/result", md_result_o, 32'd0);
        rst = 1'b0;
        tick;
        run_md("after_rst", 3'd0, 32'd5, 32'd5, 32'd25, 33);
`else
        dec("m_mul_code",  3'b000, 3'b000, 7'b0000001, 1'b1, 5'd1);
        dec("m_remu_code", 3'b000, 3'b111, 7'b0000001, 1'b1, 5'd3);
        alu_op  = 3'b000;
        funct7  = 7'b0000001;
        funct3  = 3'd0;
        rs1_i   = 32'hFFFF_FFFD;
        rs2_i   = 32'd7;
        valid_i = 1'b1;
        dones   = 0;
        repeat (5) begin
            tick;
            if (md_done_o || md_busy_o) dones++;
        end
        valid_i = 1'b0;
        chk("nomext/no_busy_done", 32'(dones), 32'd0);
        chk("nomext/result", md_result_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
